btables_ctrl: RTL and testbench

BTABLES_CTRL -- requirements
Module: btables_ctrl

---
 rtl/btables_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_btables_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btables_ctrl.sv
// btables_ctrl -- sequencer for the branch-predictor GHR and weight tables.
//
// Clears every weight row after reset, then merges fetch pushes and
// resolution weight updates into one table command per cycle. A mispredicted
// resolution emits a GHR correction command and then a weight write. After
// that write, pending work is discarded.
//
// Ports:
//   fire               clock; all state changes on its rising edge
//   i_rst              synchronous active-high reset
//   i_fetchValid_1     fetch offers i_fetchBNum_3 (1..4) new branches
//   i_fetchBNum_3      and their GHR entries on i_fetchGHR_132
//   i_fetchGHR_132
//   o_fetchStall_1     fetch not accepted this cycle (combinational handshake)
//   i_resValid_1       a resolution {mispred, row, weights} is offered
//   i_resMispred_1
//   i_resWeightPos_8
//   i_resWeights_72
//   o_resReady_1       resolution accepted when valid (combinational handshake)
//   o_tblWrite_1       table command strobe; payload below is registered
//   o_newPendingB_8
//   o_passBNum_3       GHR push count, 3'b111 = misprediction correction
//   o_newGHREntry_132
//   o_weightWe_1
//   o_errWeightPos_8
//   o_newWeights_72
//   o_pendingB_8       current in-flight branch count
//
// Optional build macro BTABLES_CTRL_STATS_EN adds o_mispredCnt_16 and
// o_cmdCnt_16. Both are saturating counts, of correction commands and of all
// table commands respectively.
module btables_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_PENDING = 20,
    parameter int TBL_ENTRIES = 228
) (
    input  logic         fire,
    input  logic         i_rst,
    input  logic         i_fetchValid_1,
    input  logic [2:0]   i_fetchBNum_3,
    input  logic [131:0] i_fetchGHR_132,
    output logic         o_fetchStall_1,
    input  logic         i_resValid_1,
    input  logic         i_resMispred_1,
    input  logic [7:0]   i_resWeightPos_8,
    input  logic [71:0]  i_resWeights_72,
    output logic         o_resReady_1,
    output logic         o_tblWrite_1,
    output logic [7:0]   o_newPendingB_8,
    output logic [2:0]   o_passBNum_3,
    output logic [131:0] o_newGHREntry_132,
    output logic         o_weightWe_1,
    output logic [7:0]   o_errWeightPos_8,
    output logic [71:0]  o_newWeights_72,
    output logic [7:0]   o_pendingB_8
`ifdef BTABLES_CTRL_STATS_EN
    ,
    output logic [15:0]  o_mispredCnt_16,
    output logic [15:0]  o_cmdCnt_16
`endif
);
    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_WFIX  = 2'd2;
    localparam logic [2:0] PASS_FIX = 3'b111;
    localparam logic [7:0] LAST_ROW = 8'(TBL_ENTRIES - 1);

    typedef struct packed {
        logic        mispred;
        logic [7:0]  pos;
        logic [71:0] weights;
    } res_t;

    res_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    sweep_q, sweep_d;
    logic [7:0]    pending_q, pending_d;
    logic [7:0]    fix_pos_q, fix_pos_d;
    logic [71:0]   fix_w_q, fix_w_d;

    logic          tbl_write_q, tbl_write_d;
    logic          weight_we_q, weight_we_d;
    logic [2:0]    pass_q, pass_d;
    logic [7:0]    new_pending_q, new_pending_d;
    logic [131:0]  ghr_q, ghr_d;
    logic [7:0]    err_pos_q, err_pos_d;
    logic [71:0]   new_w_q, new_w_d;

    res_t          head;
    logic          in_run, fifo_full, head_valid, head_mis, over_limit;
    logic          stall, ready, push, pop, flush, fetch_acc;
    logic [2:0]    acc_num;

    assign head       = fifo_mem[rd_ptr_q];
    assign in_run     = (state_q == ST_RUN);
    assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign head_valid = (count_q != '0);
    assign head_mis   = head_valid & head.mispred;
    // 9-bit sum so pending + 4 cannot wrap before the limit compare.
    assign over_limit = (9'(pending_q) + 9'(i_fetchBNum_3)) > 9'(MAX_PENDING);

    // Handshakes are combinational so a request is answered in the same cycle;
    // gating with i_rst keeps them in their reset values while reset is held.
    assign stall      = i_rst | ~in_run | over_limit | head_mis;
    assign ready      = ~i_rst & in_run & ~fifo_full;
    assign push       = i_resValid_1 & ready;
    assign fetch_acc  = i_fetchValid_1 & ~stall;
    assign acc_num    = fetch_acc ? i_fetchBNum_3 : 3'd0;

    always_comb begin
        // NOTE: every variable gets a default here so no path infers a latch.
        state_d       = state_q;
        sweep_d       = sweep_q;
        pending_d     = pending_q;
        fix_pos_d     = fix_pos_q;
        fix_w_d       = fix_w_q;
        tbl_write_d   = 1'b0;
        weight_we_d   = 1'b0;
        pass_d        = pass_q;
        new_pending_d = new_pending_q;
        ghr_d         = ghr_q;
        err_pos_d     = err_pos_q;
        new_w_d       = new_w_q;
        pop           = 1'b0;
        flush         = 1'b0;

        case (state_q)
            ST_INIT: begin
                tbl_write_d   = 1'b1;
                weight_we_d   = 1'b1;
                pass_d        = 3'd0;
                new_pending_d = 8'd0;
                err_pos_d     = sweep_q;
                new_w_d       = '0;
                if (sweep_q == LAST_ROW) begin
                    sweep_d = 8'd0;
                    state_d = ST_RUN;
                end else begin
                    sweep_d = sweep_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (head_mis) begin
                    // Correction command. The row data is replayed next cycle.
                    tbl_write_d   = 1'b1;
                    pass_d        = PASS_FIX;
                    new_pending_d = pending_q;
                    pop           = 1'b1;
                    fix_pos_d     = head.pos;
                    fix_w_d       = head.weights;
                    state_d       = ST_WFIX;
                end else if (fetch_acc | head_valid) begin
                    tbl_write_d = 1'b1;
                    pop         = head_valid;
                    weight_we_d = head_valid;
                    pass_d      = acc_num;
                    ghr_d       = i_fetchGHR_132;
                    if (head_valid) begin
                        err_pos_d = head.pos;
                        new_w_d   = head.weights;
                    end
                    // A resolution arriving with nothing pending does not decrement.
                    pending_d     = pending_q + 8'(acc_num)
                                  - 8'(head_valid && (pending_q != 8'd0));
                    new_pending_d = pending_d;
                end
            end
            ST_WFIX: begin
                tbl_write_d   = 1'b1;
                weight_we_d   = 1'b1;
                err_pos_d     = fix_pos_q;
                new_w_d       = fix_w_q;
                pass_d        = 3'd0;
                new_pending_d = 8'd0;
                pending_d     = 8'd0;
                flush         = 1'b1;
                state_d       = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge fire) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (i_rst) begin
            state_q       <= ST_INIT;
            sweep_q       <= '0;
            pending_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fix_pos_q     <= '0;
            fix_w_q       <= '0;
            tbl_write_q   <= 1'b0;
            weight_we_q   <= 1'b0;
            pass_q        <= '0;
            new_pending_q <= '0;
            ghr_q         <= '0;
            err_pos_q     <= '0;
            new_w_q       <= '0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            pending_q     <= pending_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fix_pos_q     <= fix_pos_d;
            fix_w_q       <= fix_w_d;
            tbl_write_q   <= tbl_write_d;
            weight_we_q   <= weight_we_d;
            pass_q        <= pass_d;
            new_pending_q <= new_pending_d;
            ghr_q         <= ghr_d;
            err_pos_q     <= err_pos_d;
            new_w_q       <= new_w_d;
        end
    end

    // NOTE: FIFO storage has no reset; count_q alone decides which entries are valid.
    always_ff @(posedge fire) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{mispred: i_resMispred_1,
                                    pos:     i_resWeightPos_8,
                                    weights: i_resWeights_72};
        end
    end

    assign o_fetchStall_1    = stall;
    assign o_resReady_1      = ready;
    assign o_tblWrite_1      = tbl_write_q;
    assign o_newPendingB_8   = new_pending_q;
    assign o_passBNum_3      = pass_q;
    assign o_newGHREntry_132 = ghr_q;
    assign o_weightWe_1      = weight_we_q;
    assign o_errWeightPos_8  = err_pos_q;
    assign o_newWeights_72   = new_w_q;
    assign o_pendingB_8      = pending_q;

`ifdef BTABLES_CTRL_STATS_EN
    logic        fix_cmd;
    logic [15:0] mispred_cnt_q, cmd_cnt_q;

    assign fix_cmd = in_run & head_mis;

    always_ff @(posedge fire) begin
        if (i_rst) begin
            mispred_cnt_q <= '0;
            cmd_cnt_q     <= '0;
        end else begin
            if (tbl_write_d && (cmd_cnt_q != 16'hFFFF))
                cmd_cnt_q <= cmd_cnt_q + 16'd1;
            if (fix_cmd && (mispred_cnt_q != 16'hFFFF))
                mispred_cnt_q <= mispred_cnt_q + 16'd1;
        end
    end

    assign o_mispredCnt_16 = mispred_cnt_q;
    assign o_cmdCnt_16     = cmd_cnt_q;
`endif
endmodule

// File: tb/tb_btables_ctrl.sv
`timescale 1ns/1ps
module tb_btables_ctrl;
    localparam int DEPTH = 4;
    localparam int MAXP  = 20;
    localparam int ROWS  = 228;

    logic         fire = 1'b0;
    logic         i_rst;
    logic         i_fetchValid_1;
    logic [2:0]   i_fetchBNum_3;
    logic [131:0] i_fetchGHR_132;
    logic         o_fetchStall_1;
    logic         i_resValid_1;
    logic         i_resMispred_1;
    logic [7:0]   i_resWeightPos_8;
    logic [71:0]  i_resWeights_72;
    logic         o_resReady_1;
    logic         o_tblWrite_1;
    logic [7:0]   o_newPendingB_8;
    logic [2:0]   o_passBNum_3;
    logic [131:0] o_newGHREntry_132;
    logic         o_weightWe_1;
    logic [7:0]   o_errWeightPos_8;
    logic [71:0]  o_newWeights_72;
    logic [7:0]   o_pendingB_8;
`ifdef BTABLES_CTRL_STATS_EN
    logic [15:0]  o_mispredCnt_16;
    logic [15:0]  o_cmdCnt_16;
`endif

    btables_ctrl #(.FIFO_DEPTH(DEPTH), .MAX_PENDING(MAXP), .TBL_ENTRIES(ROWS)) dut (
        .fire              (fire),
        .i_rst             (i_rst),
        .i_fetchValid_1    (i_fetchValid_1),
        .i_fetchBNum_3     (i_fetchBNum_3),
        .i_fetchGHR_132    (i_fetchGHR_132),
        .o_fetchStall_1    (o_fetchStall_1),
        .i_resValid_1      (i_resValid_1),
        .i_resMispred_1    (i_resMispred_1),
        .i_resWeightPos_8  (i_resWeightPos_8),
        .i_resWeights_72   (i_resWeights_72),
        .o_resReady_1      (o_resReady_1),
        .o_tblWrite_1      (o_tblWrite_1),
        .o_newPendingB_8   (o_newPendingB_8),
        .o_passBNum_3      (o_passBNum_3),
        .o_newGHREntry_132 (o_newGHREntry_132),
        .o_weightWe_1      (o_weightWe_1),
        .o_errWeightPos_8  (o_errWeightPos_8),
        .o_newWeights_72   (o_newWeights_72),
        .o_pendingB_8      (o_pendingB_8)
`ifdef BTABLES_CTRL_STATS_EN
        ,
        .o_mispredCnt_16   (o_mispredCnt_16),
        .o_cmdCnt_16       (o_cmdCnt_16)
`endif
    );

    always #5 fire = ~fire;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_INIT, M_RUN, M_FIX} mode_t;
    typedef struct {
        bit          mis;
        logic [7:0]  pos;
        logic [71:0] w;
    } res_t;

    mode_t        m_mode;
    int           m_sweep, m_pend;
    res_t         m_q[$];
    res_t         m_fix;
    bit           e_tw, e_we;
    int           e_pass, e_np, e_pos;
    logic [131:0] e_ghr;
    logic [71:0]  e_w;

    function automatic bit exp_stall();
        return i_rst || (m_mode != M_RUN) || (m_pend + int'(i_fetchBNum_3) > MAXP)
               || (m_q.size() > 0 && m_q[0].mis);
    endfunction

    function automatic bit exp_ready();
        return !i_rst && (m_mode == M_RUN) && (m_q.size() < DEPTH);
    endfunction

    task automatic model_edge();
        bit   st, acc, pop, psh;
        int   n;
        res_t h;
        st  = exp_stall();
        psh = exp_ready() && i_resValid_1;
        if (i_rst) begin
            m_mode = M_INIT; m_sweep = 0; m_pend = 0; m_q.delete();
            e_tw = 0; e_we = 0; e_pass = 0; e_np = 0; e_pos = 0; e_ghr = '0; e_w = '0;
            return;
        end
        case (m_mode)
            M_INIT: begin
                e_tw = 1; e_we = 1; e_pass = 0; e_np = 0; e_pos = m_sweep; e_w = '0;
                m_sweep++;
                if (m_sweep == ROWS) begin m_mode = M_RUN; m_sweep = 0; end
            end
            M_RUN: begin
                if (m_q.size() > 0 && m_q[0].mis) begin
                    e_tw = 1; e_we = 0; e_pass = 7; e_np = m_pend;
                    m_fix  = m_q.pop_front();
                    m_mode = M_FIX;
                end else begin
                    acc = i_fetchValid_1 && !st;
                    pop = m_q.size() > 0;
                    n   = acc ? int'(i_fetchBNum_3) : 0;
                    if (acc || pop) begin
                        e_tw = 1; e_we = pop; e_pass = n; e_ghr = i_fetchGHR_132;
                        if (pop) begin
                            h = m_q.pop_front();
                            e_pos = h.pos; e_w = h.w;
                            if (m_pend > 0) m_pend--;
                        end
                        m_pend += n;
                        e_np = m_pend;
                    end else begin
                        e_tw = 0; e_we = 0;
                    end
                end
                if (psh) m_q.push_back('{mis: i_resMispred_1, pos: i_resWeightPos_8, w: i_resWeights_72});
            end
            M_FIX: begin
                e_tw = 1; e_we = 1; e_pass = 0; e_np = 0; e_pos = m_fix.pos; e_w = m_fix.w;
                m_pend = 0; m_q.delete(); m_mode = M_RUN;
            end
            default: m_mode = M_INIT;
        endcase
    endtask

    // One clock cycle: handshake checks before the edge, registered checks after.
    task automatic step();
        #1;
        check("stall", 132'(o_fetchStall_1), 132'(exp_stall()));
        check("ready", 132'(o_resReady_1), 132'(exp_ready()));
        model_edge();
        @(posedge fire);
        #1;
        check("tblWrite", 132'(o_tblWrite_1), 132'(e_tw));
        check("weightWe", 132'(o_weightWe_1), 132'(e_we));
        check("passBNum", 132'(o_passBNum_3), 132'(e_pass));
        check("newPendingB", 132'(o_newPendingB_8), 132'(e_np));
        check("ghr", o_newGHREntry_132, e_ghr);
        check("errPos", 132'(o_errWeightPos_8), 132'(e_pos));
        check("newWeights", 132'(o_newWeights_72), 132'(e_w));
        check("pendingB", 132'(o_pendingB_8), 132'(m_pend));
    endtask

    function automatic logic [71:0] mkw(input int pos);
        logic [8:0] p;
        p = 9'(pos);
        return {8{p}};
    endfunction

    function automatic logic [71:0] rand_w();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[71:0];
    endfunction

    function automatic logic [131:0] rand_ghr();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[131:0];
    endfunction

    task automatic drive(input bit fv, input int bn, input bit rv, input bit rm,
                         input int pos, input logic [71:0] w);
        i_fetchValid_1   = fv;
        i_fetchBNum_3    = 3'(bn);
        i_fetchGHR_132   = rand_ghr();
        i_resValid_1     = rv;
        i_resMispred_1   = rm;
        i_resWeightPos_8 = 8'(pos);
        i_resWeights_72  = w;
    endtask

    typedef struct {
        int fv, bn, rv, rm, rpos;
        int stall, ready;
        int tw, pass, np, we, pos, pend;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int n_init;
        vecs[0]  = '{1,3, 0,0, 0,  0,1, 1,3,3,  0,227, 3};
        vecs[1]  = '{0,0, 1,0,11,  0,1, 0,3,3,  0,227, 3};
        vecs[2]  = '{1,2, 0,0, 0,  0,1, 1,2,4,  1,11,  4};
        vecs[3]  = '{1,1, 0,0, 0,  0,1, 1,1,5,  0,11,  5};
        vecs[4]  = '{0,0, 1,1,22,  0,1, 0,1,5,  0,11,  5};
        vecs[5]  = '{0,0, 0,0, 0,  1,1, 1,7,5,  0,11,  5};
        vecs[6]  = '{0,0, 0,0, 0,  1,0, 1,0,0,  1,22,  0};
        vecs[7]  = '{0,0, 1,0,33,  0,1, 0,0,0,  0,22,  0};
        vecs[8]  = '{0,0, 0,0, 0,  0,1, 1,0,0,  1,33,  0};
        vecs[9]  = '{1,4, 0,0, 0,  0,1, 1,4,4,  0,33,  4};
        vecs[10] = '{1,4, 0,0, 0,  0,1, 1,4,8,  0,33,  8};
        vecs[11] = '{1,4, 0,0, 0,  0,1, 1,4,12, 0,33, 12};
        vecs[12] = '{1,4, 0,0, 0,  0,1, 1,4,16, 0,33, 16};
        vecs[13] = '{1,3, 0,0, 0,  0,1, 1,3,19, 0,33, 19};
        vecs[14] = '{1,2, 0,0, 0,  1,1, 0,3,19, 0,33, 19};
        vecs[15] = '{1,1, 0,0, 0,  0,1, 1,1,20, 0,33, 20};
        vecs[16] = '{1,1, 0,0, 0,  1,1, 0,1,20, 0,33, 20};
        vecs[17] = '{0,0, 1,0,44,  0,1, 0,1,20, 0,33, 20};
        vecs[18] = '{1,1, 0,0, 0,  1,1, 1,0,19, 1,44, 19};

        i_rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0);
        m_mode = M_INIT; m_sweep = 0; m_pend = 0;
        repeat (3) step();
        i_rst = 1'b0;

        // Full clearing sweep after reset release.
        n_init = 0;
        for (int c = 0; c < ROWS + 10 && o_fetchStall_1; c++) begin
            step();
            if (o_tblWrite_1 && o_weightWe_1) begin
                check("init_row", 132'(o_errWeightPos_8), 132'(n_init));
                n_init++;
            end
        end
        check("init_count", 132'(n_init), 132'(ROWS));
        check("init_done_stall", 132'(o_fetchStall_1), 132'(0));

        // Directed vectors from the end of the sweep.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].fv != 0, vecs[i].bn, vecs[i].rv != 0, vecs[i].rm != 0,
                  vecs[i].rpos, mkw(vecs[i].rpos));
            #1;
            check($sformatf("v%0d_stall", i), 132'(o_fetchStall_1), 132'(vecs[i].stall));
            check($sformatf("v%0d_ready", i), 132'(o_resReady_1), 132'(vecs[i].ready));
            step();
            check($sformatf("v%0d_tw", i), 132'(o_tblWrite_1), 132'(vecs[i].tw));
            check($sformatf("v%0d_pass", i), 132'(o_passBNum_3), 132'(vecs[i].pass));
            check($sformatf("v%0d_np", i), 132'(o_newPendingB_8), 132'(vecs[i].np));
            check($sformatf("v%0d_we", i), 132'(o_weightWe_1), 132'(vecs[i].we));
            check($sformatf("v%0d_pos", i), 132'(o_errWeightPos_8), 132'(vecs[i].pos));
            check($sformatf("v%0d_pend", i), 132'(o_pendingB_8), 132'(vecs[i].pend));
            if (vecs[i].we != 0)
                check($sformatf("v%0d_w", i), 132'(o_newWeights_72), 132'(mkw(vecs[i].pos)));
        end

        // Reset while the weight fix is pending abandons it and restarts the sweep.
        drive(0, 0, 1, 1, 55, mkw(55));
        step();
        drive(0, 0, 0, 0, 0, '0);
        step();
        check("fix_cmd_pass", 132'(o_passBNum_3), 132'(7));
        i_rst = 1'b1;
        step();
        check("wfix_rst_tw", 132'(o_tblWrite_1), 132'(0));
        check("wfix_rst_pend", 132'(o_pendingB_8), 132'(0));
        i_rst = 1'b0;
        step();
        check("wfix_rst_row0_tw", 132'(o_tblWrite_1), 132'(1));
        check("wfix_rst_row0", 132'(o_errWeightPos_8), 132'(0));

        // Reset in the middle of the sweep restarts it at row 0.
        repeat (50) step();
        check("mid_init_row", 132'(o_errWeightPos_8), 132'(50));
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        step();
        check("mid_init_restart", 132'(o_errWeightPos_8), 132'(0));
        repeat (ROWS + 2) step();
        check("resweep_done", 132'(o_fetchStall_1), 132'(0));

        // Randomized traffic against the model, with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(1, 4),
                  $urandom_range(0, 4) < 2, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 255), rand_w());
            i_rst = ($urandom_range(0, 299) == 0);
            step();
        end
        i_rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
